// File: rtl/writeback_ctrl.sv
// writeback_ctrl: single write-port initiator for the register file.
// Takes one retiring instruction, waits for load data when needed,
// aligns/extends sub-word loads, picks the destination register and
// issues a one-cycle write strobe with registered address/data.
module writeback_ctrl #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [5:0]        issue_opcode,
  input  logic [REG_AW-1:0] issue_rt,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [DATA_W-1:0] issue_pc,
  input  logic [DATA_W-1:0] issue_alu,
  input  logic              issue_reg_write,
  input  logic              issue_rt_rd,
  input  logic [1:0]        issue_byte_off,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    COMMIT    = 2'd2
  } state_t;

  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;

  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
  localparam logic [REG_AW-1:0] REG_RA   = {REG_AW{1'b1}};
  localparam logic [DATA_W-1:0] PC_STEP  = {{(DATA_W-3){1'b0}}, 3'd4};

  // Selects the addressed lane/halfword of a load word and extends it to
  // a full register; the register is always overwritten in full.
  function automatic logic [DATA_W-1:0] extract_load(
    input logic [5:0]        op,
    input logic [1:0]        off,
    input logic [DATA_W-1:0] rdata
  );
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DATA_W-1:0] res_v;
    case (off)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    // off[0] is irrelevant for halfwords: only aligned halves are selected
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   res_v = {{(DATA_W-8){byte_v[7]}}, byte_v};
      OP_LBU:  res_v = {{(DATA_W-8){1'b0}}, byte_v};
      OP_LH:   res_v = {{(DATA_W-16){half_v[15]}}, half_v};
      OP_LHU:  res_v = {{(DATA_W-16){1'b0}}, half_v};
      OP_LW:   res_v = rdata;
      default: res_v = rdata;
    endcase
    return res_v;
  endfunction

  state_t            state_r, state_next_s;
  logic [5:0]        ld_op_r, ld_op_next_s;
  logic [REG_AW-1:0] ld_dest_r, ld_dest_next_s;
  logic [1:0]        ld_off_r, ld_off_next_s;
  logic              wr_en_r, wr_en_next_s;
  logic [REG_AW-1:0] wr_addr_r, wr_addr_next_s;
  logic [DATA_W-1:0] wr_data_r, wr_data_next_s;
  logic              is_load_s;
  logic [REG_AW-1:0] alu_dest_s;

  // Opcode classification and destination choice for non-jal writers
  always_comb begin
    is_load_s  = 1'b0;
    alu_dest_s = issue_rt_rd ? issue_rt : issue_rd;
    case (issue_opcode)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load_s = 1'b1;
      default:                             is_load_s = 1'b0;
    endcase
  end

  // Next-state and next-output logic; write strobe is prepared one edge
  // ahead so wr_en is high exactly while the FSM sits in COMMIT
  always_comb begin
    state_next_s   = state_r;
    ld_op_next_s   = ld_op_r;
    ld_dest_next_s = ld_dest_r;
    ld_off_next_s  = ld_off_r;
    wr_en_next_s   = 1'b0;
    wr_addr_next_s = wr_addr_r;
    wr_data_next_s = wr_data_r;
    case (state_r)
      IDLE: begin
        if (issue_valid) begin
          if (issue_opcode == OP_JAL) begin
            // link write happens regardless of issue_reg_write
            state_next_s   = COMMIT;
            wr_en_next_s   = 1'b1;
            wr_addr_next_s = REG_RA;
            wr_data_next_s = issue_pc + PC_STEP;
          end else if (is_load_s) begin
            state_next_s   = LOAD_WAIT;
            ld_op_next_s   = issue_opcode;
            ld_dest_next_s = issue_rt;
            ld_off_next_s  = issue_byte_off;
          end else if (issue_reg_write) begin
            state_next_s = COMMIT;
            if (alu_dest_s != REG_ZERO) begin
              wr_en_next_s   = 1'b1;
              wr_addr_next_s = alu_dest_s;
              wr_data_next_s = issue_alu;
            end else begin
              wr_en_next_s = 1'b0;
            end
          end else begin
            // consumed with no register effect
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD_WAIT: begin
        if (mem_rvalid) begin
          state_next_s = COMMIT;
          if (ld_dest_r != REG_ZERO) begin
            wr_en_next_s   = 1'b1;
            wr_addr_next_s = ld_dest_r;
            wr_data_next_s = extract_load(ld_op_r, ld_off_r, mem_rdata);
          end else begin
            wr_en_next_s = 1'b0;
          end
        end else begin
          state_next_s = LOAD_WAIT;
        end
      end
      COMMIT: begin
        state_next_s = IDLE;
        wr_en_next_s = 1'b0;
      end
      default: begin
        state_next_s = IDLE;
        wr_en_next_s = 1'b0;
      end
    endcase
  end

  // State, captured load context and registered write-port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      ld_op_r   <= 6'd0;
      ld_dest_r <= REG_ZERO;
      ld_off_r  <= 2'd0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= REG_ZERO;
      wr_data_r <= {DATA_W{1'b0}};
    end else begin
      state_r   <= state_next_s;
      ld_op_r   <= ld_op_next_s;
      ld_dest_r <= ld_dest_next_s;
      ld_off_r  <= ld_off_next_s;
      wr_en_r   <= wr_en_next_s;
      wr_addr_r <= wr_addr_next_s;
      wr_data_r <= wr_data_next_s;
    end
  end

  assign issue_ready = (state_r == IDLE);
  assign busy        = (state_r != IDLE);
  assign wr_en       = wr_en_r;
  assign wr_addr     = wr_addr_r;
  assign wr_data     = wr_data_r;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Directed bench for writeback_ctrl with a write scoreboard.
module tb_writeback_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  issue_opcode;
  logic [4:0]  issue_rt;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc;
  logic [31:0] issue_alu;
  logic        issue_reg_write;
  logic        issue_rt_rd;
  logic [1:0]  issue_byte_off;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  busy_cnt;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;

  writeback_ctrl #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_opcode(issue_opcode), .issue_rt(issue_rt), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_alu(issue_alu),
    .issue_reg_write(issue_reg_write), .issue_rt_rd(issue_rt_rd),
    .issue_byte_off(issue_byte_off),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every observed write must match the oldest expected write
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      chk("sb_write_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("sb_addr", 32'(wr_addr), 32'(e.addr));
        chk("sb_data", wr_data, e.data);
      end
    end
  end

  // Present one instruction for one accept edge (called at a negedge)
  task automatic issue(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] alu,
                       input logic rw, input logic rtrd, input logic [1:0] off);
    issue_valid     = 1'b1;
    issue_opcode    = op;
    issue_rt        = rt;
    issue_rd        = rd;
    issue_pc        = pc;
    issue_alu       = alu;
    issue_reg_write = rw;
    issue_rt_rd     = rtrd;
    issue_byte_off  = off;
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  // Non-load writer: COMMIT in the cycle after accept, IDLE one cycle later
  task automatic do_write(input string tag, input logic [5:0] op, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] alu,
                          input logic rtrd, input logic exp_en,
                          input logic [4:0] exp_addr, input logic [31:0] exp_data);
    if (exp_en) exp_q.push_back(wr_t'{addr: exp_addr, data: exp_data});
    issue(op, rt, rd, pc, alu, 1'b1, rtrd, 2'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'(exp_en));
    chk({tag, "_ready_low"}, 32'(issue_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_ready_back"}, 32'(issue_ready), 32'd1);
    chk({tag, "_wr_en_drop"}, 32'(wr_en), 32'd0);
  endtask

  // Load with earliest possible mem_rvalid (sampled on the edge after accept)
  task automatic do_load(input string tag, input logic [5:0] op, input logic [4:0] rt,
                         input logic [1:0] off, input logic [31:0] rdata,
                         input logic [31:0] exp_data);
    exp_q.push_back(wr_t'{addr: rt, data: exp_data});
    issue(op, rt, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, off);
    chk({tag, "_wait_no_wr"}, 32'(wr_en), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'hDEAD_0000;
    chk({tag, "_commit_wr_en"}, 32'(wr_en), 32'd1);
    chk({tag, "_commit_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({tag, "_idle_ready"}, 32'(issue_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0; issue_opcode = 6'd0; issue_rt = 5'd0; issue_rd = 5'd0;
    issue_pc = 32'd0; issue_alu = 32'd0; issue_reg_write = 1'b0; issue_rt_rd = 1'b0;
    issue_byte_off = 2'd0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_ready", 32'(issue_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_write("rd_type", OP_R, 5'd7, 5'd5, 32'd0, 32'h0000_1234, 1'b0, 1'b1, 5'd5, 32'h0000_1234);
    do_write("jal", OP_JAL, 5'd0, 5'd0, 32'h0040_0020, 32'd0, 1'b0, 1'b1, 5'd31, 32'h0040_0024);
    do_write("jal_wrap", OP_JAL, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'd0, 1'b0, 1'b1, 5'd31, 32'h0000_0000);
    do_write("rt_dest", OP_ADDI, 5'd3, 5'd9, 32'd0, 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF);

    do_load("lb_off2", OP_LB, 5'd9, 2'd2, 32'h1280_3456, 32'hFFFF_FF80);
    do_load("lbu_off2", OP_LBU, 5'd9, 2'd2, 32'h1280_3456, 32'h0000_0080);
    do_load("lb_off0", OP_LB, 5'd9, 2'd0, 32'h1280_3456, 32'h0000_0056);
    do_load("lh_off2", OP_LH, 5'd10, 2'd2, 32'h8001_7FFF, 32'hFFFF_8001);
    do_load("lhu_off3", OP_LHU, 5'd10, 2'd3, 32'h8001_7FFF, 32'h0000_8001);
    do_load("lh_off0", OP_LH, 5'd10, 2'd0, 32'h8001_7FFF, 32'h0000_7FFF);

    // lw with late data: busy spans LOAD_WAIT (3 cycles) plus COMMIT
    exp_q.push_back(wr_t'{addr: 5'd12, data: 32'h8001_7FFF});
    mem_rdata = 32'h8001_7FFF;
    issue(OP_LW, 5'd12, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 2'd1);
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      mem_rvalid = (c == 2);
    end
    chk("lw_busy_cycles", 32'(busy_cnt), 32'd4);

    // dest 0: COMMIT still taken, no strobe, outputs keep last write
    issue(OP_R, 5'd4, 5'd0, 32'd0, 32'h5555_AAAA, 1'b1, 1'b0, 2'd0);
    chk("rd0_busy", 32'(busy), 32'd1);
    chk("rd0_wr_en", 32'(wr_en), 32'd0);
    chk("rd0_addr_hold", 32'(wr_addr), 32'd12);
    chk("rd0_data_hold", wr_data, 32'h8001_7FFF);
    @(negedge clk);
    chk("rd0_ready_back", 32'(issue_ready), 32'd1);

    // reg_write=0 non-jal: consumed without leaving IDLE
    issue(OP_R, 5'd4, 5'd6, 32'd0, 32'h1111_2222, 1'b0, 1'b0, 2'd0);
    chk("nowr_ready", 32'(issue_ready), 32'd1);
    chk("nowr_busy", 32'(busy), 32'd0);
    chk("nowr_wr_en", 32'(wr_en), 32'd0);

    // stray mem_rvalid in IDLE has no effect
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("idle_rvalid_wr_en", 32'(wr_en), 32'd0);
    chk("idle_rvalid_ready", 32'(issue_ready), 32'd1);

    // reset during LOAD_WAIT drops the load
    issue(OP_LW, 5'd7, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 2'd0);
    chk("rstld_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstld_wr_en", 32'(wr_en), 32'd0);
    chk("rstld_addr", 32'(wr_addr), 32'd0);
    chk("rstld_data", wr_data, 32'd0);
    chk("rstld_ready", 32'(issue_ready), 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rstld_late_rvalid", 32'(wr_en), 32'd0);
    @(negedge clk);
    chk("rstld_still_idle", 32'(busy), 32'd0);
    chk("rstld_no_write", 32'(wr_en), 32'd0);

    chk("sb_all_written", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
